// File: rtl/irq_trap_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : irq_trap_arbiter
// Purpose  : Interrupt front-end beside the CSR file. It owns mie, mip and
//            mideleg and the sie/sip views onto them. It synchronises the
//            external interrupt lines and picks the winning cause. The winner
//            is offered to commit over a valid/ready handshake.
// Ports    : clk, rstn (async, active-low)
//            irq_ext_i[NUM_SRC]  async level lines (bits 3/7/11 ignored)
//            msip_i, timer_irq_i machine software / timer levels
//            priv_i, mstatus_mie_i, mstatus_sie_i  current privilege/enables
//            csr_we_i/csr_waddr_i/csr_wdata_i       CSR write port
//            csr_raddr_i/csr_rdata_o                combinational CSR read
//            irq_valid_o/irq_cause_o/irq_to_s_o/irq_ready_i  offer handshake
// Config   : define TRAP_TIMER_EN to add the internal mtime/mtimecmp timer
//            (0x7C0/0x7C1). Without it, MTIP comes straight from timer_irq_i.
// Revision : 1.0 - initial release
// ============================================================================
module irq_trap_arbiter #(
  parameter int              XLEN        = 64,
  parameter int              NUM_SRC     = 16,
  parameter int              SYNC_STAGES = 2,
  parameter logic [XLEN-1:0] SW_IP_MASK  = 'h222
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] irq_ext_i,
  input  logic               msip_i,
  input  logic               timer_irq_i,
  input  logic [1:0]         priv_i,
  input  logic               mstatus_mie_i,
  input  logic               mstatus_sie_i,
  input  logic               csr_we_i,
  input  logic [11:0]        csr_waddr_i,
  input  logic [XLEN-1:0]    csr_wdata_i,
  input  logic [11:0]        csr_raddr_i,
  output logic [XLEN-1:0]    csr_rdata_o,
  output logic               irq_valid_o,
  output logic [XLEN-1:0]    irq_cause_o,
  output logic               irq_to_s_o,
  input  logic               irq_ready_i
);

  localparam logic [11:0] c_addr_mideleg  = 12'h303;
  localparam logic [11:0] c_addr_mie      = 12'h304;
  localparam logic [11:0] c_addr_mip      = 12'h344;
  localparam logic [11:0] c_addr_sie      = 12'h104;
  localparam logic [11:0] c_addr_sip      = 12'h144;
  localparam logic [11:0] c_addr_mtime    = 12'h7C0;
  localparam logic [11:0] c_addr_mtimecmp = 12'h7C1;
  localparam int          c_idx_w         = $clog2(NUM_SRC);

  // Bits 3, 7 and 11 are machine-internal sources; external lines there are dropped.
  localparam logic [NUM_SRC-1:0] c_ext_ign = NUM_SRC'(16'h0888);
  localparam logic [NUM_SRC-1:0] c_sw_mask = SW_IP_MASK[NUM_SRC-1:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFER  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_SRC-1:0]   r_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0]   r_mie;
  logic [NUM_SRC-1:0]   r_mideleg;
  logic [NUM_SRC-1:0]   r_sw_ip;
  logic [XLEN-1:0]      r_cause;
  logic                 r_to_s;
  logic [NUM_SRC-1:0]   w_wdata;
  logic [NUM_SRC-1:0]   w_sip_wmask;
  logic [NUM_SRC-1:0]   w_mip;
  logic [NUM_SRC-1:0]   w_m_elig;
  logic [NUM_SRC-1:0]   w_s_elig;
  logic [NUM_SRC-1:0]   w_pick_vec;
  logic [c_idx_w-1:0]   w_win_idx;
  logic                 w_m_en;
  logic                 w_s_en;
  logic                 w_any;
  logic                 w_mtip;
  logic                 w_unused;

  assign w_wdata     = csr_wdata_i[NUM_SRC-1:0];
  assign w_sip_wmask = c_sw_mask & r_mideleg;

  // --------------------------------------------------------------------------
  // External line synchronisers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= irq_ext_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // --------------------------------------------------------------------------
  // Machine timer source
  // --------------------------------------------------------------------------
`ifdef TRAP_TIMER_EN
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [63:0] w_wdata64;

  assign w_wdata64 = 64'(csr_wdata_i);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
    end else begin
      // A software write to mtime takes precedence over the free-running increment.
      if (csr_we_i && csr_waddr_i == c_addr_mtime) r_mtime <= w_wdata64;
      else                                         r_mtime <= r_mtime + 64'd1;
      if (csr_we_i && csr_waddr_i == c_addr_mtimecmp) r_mtimecmp <= w_wdata64;
    end
  end

  assign w_mtip   = (r_mtime >= r_mtimecmp);
  assign w_unused = ^{csr_wdata_i, timer_irq_i};
`else
  assign w_mtip   = timer_irq_i;
  assign w_unused = ^csr_wdata_i;
`endif

  assign w_mip = (r_sync[SYNC_STAGES-1] & ~c_ext_ign)
               | (NUM_SRC'(w_mtip) << 7)
               | (NUM_SRC'(msip_i) << 3)
               | r_sw_ip;

  // --------------------------------------------------------------------------
  // CSR write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mie     <= '0;
      r_mideleg <= '0;
      r_sw_ip   <= '0;
    end else if (csr_we_i) begin
      case (csr_waddr_i)
        c_addr_mideleg: r_mideleg <= w_wdata;
        c_addr_mie:     r_mie     <= w_wdata;
        c_addr_mip:     r_sw_ip   <= (r_sw_ip & ~c_sw_mask) | (w_wdata & c_sw_mask);
        // The S views only reach bits that have been delegated.
        c_addr_sie:     r_mie     <= (r_mie & ~r_mideleg) | (w_wdata & r_mideleg);
        c_addr_sip:     r_sw_ip   <= (r_sw_ip & ~w_sip_wmask) | (w_wdata & w_sip_wmask);
        default:        ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // CSR read port
  // --------------------------------------------------------------------------
  always_comb begin
    csr_rdata_o = '0;
    case (csr_raddr_i)
      c_addr_mideleg:  csr_rdata_o = XLEN'(r_mideleg);
      c_addr_mie:      csr_rdata_o = XLEN'(r_mie);
      c_addr_mip:      csr_rdata_o = XLEN'(w_mip);
      c_addr_sie:      csr_rdata_o = XLEN'(r_mie & r_mideleg);
      c_addr_sip:      csr_rdata_o = XLEN'(w_mip & r_mideleg);
`ifdef TRAP_TIMER_EN
      c_addr_mtime:    csr_rdata_o = XLEN'(r_mtime);
      c_addr_mtimecmp: csr_rdata_o = XLEN'(r_mtimecmp);
`endif
      default:         csr_rdata_o = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Eligibility and priority
  // --------------------------------------------------------------------------
  assign w_m_en     = (priv_i != 2'd3) || mstatus_mie_i;
  assign w_s_en     = (priv_i == 2'd0) || (priv_i == 2'd1 && mstatus_sie_i);
  assign w_m_elig   = r_mie & w_mip & ~r_mideleg & {NUM_SRC{w_m_en}};
  assign w_s_elig   = r_mie & w_mip &  r_mideleg & {NUM_SRC{w_s_en}};
  // Any M-level candidate shadows every S-level one.
  assign w_pick_vec = (|w_m_elig) ? w_m_elig : w_s_elig;
  assign w_any      = |w_pick_vec;

  always_comb begin
    w_win_idx = '0;
    // Descending scan so the lowest pending index is the last assignment.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_pick_vec[i]) w_win_idx = c_idx_w'(i);
    end
    // Fixed-order causes override, weakest first so the strongest lands last.
    if (w_pick_vec[5])  w_win_idx = c_idx_w'(5);
    if (w_pick_vec[1])  w_win_idx = c_idx_w'(1);
    if (w_pick_vec[9])  w_win_idx = c_idx_w'(9);
    if (w_pick_vec[7])  w_win_idx = c_idx_w'(7);
    if (w_pick_vec[3])  w_win_idx = c_idx_w'(3);
    if (w_pick_vec[11]) w_win_idx = c_idx_w'(11);
  end

  // --------------------------------------------------------------------------
  // Offer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_state_nxt = ST_OFFER;
      // Once offered, the cause is never withdrawn; only acceptance moves on.
      ST_OFFER:  if (irq_ready_i) w_state_nxt = ST_SETTLE;
      ST_SETTLE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Cause and target are captured only when leaving IDLE, so they stay frozen
  // through OFFER and SETTLE regardless of what the sources do.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cause <= '0;
      r_to_s  <= 1'b0;
    end else if (r_state == ST_IDLE && w_any) begin
      r_cause <= {1'b1, (XLEN-1)'(w_win_idx)};
      r_to_s  <= ~(|w_m_elig);
    end
  end

  assign irq_valid_o = (r_state == ST_OFFER);
  assign irq_cause_o = r_cause;
  assign irq_to_s_o  = r_to_s;

endmodule
`default_nettype wire

// File: tb/tb_irq_trap_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_trap_arbiter
// Purpose  : Self-checking bench for irq_trap_arbiter (default parameters).
//            A behavioural model tracks the CSR shadows, the delayed external
//            lines and the offer handshake; a compare process checks every
//            output each cycle, and directed scenarios pin key values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_trap_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] irq_ext_i = '0;
  logic        msip_i = 1'b0;
  logic        timer_irq_i = 1'b0;
  logic [1:0]  priv_i = 2'd0;
  logic        mstatus_mie_i = 1'b0;
  logic        mstatus_sie_i = 1'b0;
  logic        csr_we_i = 1'b0;
  logic [11:0] csr_waddr_i = '0;
  logic [63:0] csr_wdata_i = '0;
  logic [11:0] csr_raddr_i = 12'h304;
  logic [63:0] csr_rdata_o;
  logic        irq_valid_o;
  logic [63:0] irq_cause_o;
  logic        irq_to_s_o;
  logic        irq_ready_i = 1'b0;

  irq_trap_arbiter #(
    .XLEN(64), .NUM_SRC(16), .SYNC_STAGES(2), .SW_IP_MASK(64'h222)
  ) dut (
    .clk(clk), .rstn(rstn), .irq_ext_i(irq_ext_i), .msip_i(msip_i),
    .timer_irq_i(timer_irq_i), .priv_i(priv_i), .mstatus_mie_i(mstatus_mie_i),
    .mstatus_sie_i(mstatus_sie_i), .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i),
    .csr_wdata_i(csr_wdata_i), .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o),
    .irq_valid_o(irq_valid_o), .irq_cause_o(irq_cause_o), .irq_to_s_o(irq_to_s_o),
    .irq_ready_i(irq_ready_i)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  logic [15:0] m_mie = '0, m_mideleg = '0, m_swip = '0;
  logic [15:0] m_hist[$] = '{16'h0, 16'h0};   // oldest first, one entry per stage
  int          m_phase = 0;                   // 0 idle, 1 offering, 2 settling
  logic [63:0] m_cause = '0;
  logic        m_to_s = 1'b0;
  logic [15:0] m_mipv, m_me, m_se, m_wd;
  int          m_w;
`ifdef TRAP_TIMER_EN
  logic [63:0] m_mtime = '0, m_mtimecmp = '1;
`endif

  function automatic logic m_mtip();
`ifdef TRAP_TIMER_EN
    return m_mtime >= m_mtimecmp;
`else
    return timer_irq_i;
`endif
  endfunction

  function automatic logic [15:0] m_mip();
    logic [15:0] v;
    v = m_hist[0] & ~16'h0888;
    if (m_mtip()) v[7] = 1'b1;
    if (msip_i)   v[3] = 1'b1;
    return v | m_swip;
  endfunction

  function automatic int m_pick(input logic [15:0] v);
    int ord[6] = '{11, 3, 7, 9, 1, 5};
    foreach (ord[k]) if (v[ord[k]]) return ord[k];
    for (int b = 0; b < 16; b++) if (v[b]) return b;
    return -1;
  endfunction

  function automatic logic [63:0] m_rd(input logic [11:0] a);
    case (a)
      12'h303: return {48'h0, m_mideleg};
      12'h304: return {48'h0, m_mie};
      12'h344: return {48'h0, m_mip()};
      12'h104: return {48'h0, m_mie & m_mideleg};
      12'h144: return {48'h0, m_mip() & m_mideleg};
`ifdef TRAP_TIMER_EN
      12'h7C0: return m_mtime;
      12'h7C1: return m_mtimecmp;
`endif
      default: return 64'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mie = '0; m_mideleg = '0; m_swip = '0;
      m_hist = '{16'h0, 16'h0};
      m_phase = 0; m_cause = '0; m_to_s = 1'b0;
`ifdef TRAP_TIMER_EN
      m_mtime = '0; m_mtimecmp = '1;
`endif
    end else begin
      m_mipv = m_mip();
      m_me = (priv_i < 2'd3 || mstatus_mie_i) ? (m_mie & m_mipv & ~m_mideleg) : 16'h0;
      m_se = (priv_i == 2'd0 || (priv_i == 2'd1 && mstatus_sie_i)) ?
             (m_mie & m_mipv & m_mideleg) : 16'h0;
      case (m_phase)
        0: if ((m_me | m_se) != 16'h0) begin
             m_w     = (m_me != 16'h0) ? m_pick(m_me) : m_pick(m_se);
             m_cause = {1'b1, 63'(m_w)};
             m_to_s  = (m_me == 16'h0);
             m_phase = 1;
           end
        1: if (irq_ready_i) m_phase = 2;
        default: m_phase = 0;
      endcase
      m_wd = csr_wdata_i[15:0];
      if (csr_we_i) begin
        case (csr_waddr_i)
          12'h303: m_mideleg = m_wd;
          12'h304: m_mie     = m_wd;
          12'h344: m_swip    = m_wd & 16'h0222;
          12'h104: m_mie     = (m_mie & ~m_mideleg) | (m_wd & m_mideleg);
          12'h144: m_swip    = (m_swip & ~(m_mideleg & 16'h0222)) | (m_wd & m_mideleg & 16'h0222);
          default: ;
        endcase
      end
`ifdef TRAP_TIMER_EN
      if (csr_we_i && csr_waddr_i == 12'h7C0) m_mtime = csr_wdata_i;
      else                                    m_mtime = m_mtime + 64'd1;
      if (csr_we_i && csr_waddr_i == 12'h7C1) m_mtimecmp = csr_wdata_i;
`endif
      m_hist.push_back(irq_ext_i);
      void'(m_hist.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("valid", 64'(irq_valid_o), 64'(m_phase == 1));
    chk("cause", irq_cause_o, m_cause);
    chk("to_s",  64'(irq_to_s_o), 64'(m_to_s));
    chk("rdata", csr_rdata_o, m_rd(csr_raddr_i));
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    csr_we_i = 1'b1; csr_waddr_i = a; csr_wdata_i = d;
    tick();
    csr_we_i = 1'b0;
  endtask

  logic [11:0] rd_addrs[5] = '{12'h303, 12'h304, 12'h344, 12'h104, 12'h144};
`ifdef TRAP_TIMER_EN
  logic        tm_found;
  logic [63:0] tm_seen;
`endif

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(irq_valid_o), 64'd0);
    chk("rst_cause", irq_cause_o, 64'd0);
    chk("rst_mie",   csr_rdata_o, 64'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // M timer interrupt, taken from U-mode
    priv_i = 2'd0;
    wr(12'h304, 64'h80);
    timer_irq_i = 1'b1;
    tick();
    @(negedge clk);
    chk("tmr_valid", 64'(irq_valid_o), 64'd1);
    chk("tmr_cause", irq_cause_o, 64'h8000_0000_0000_0007);
    chk("tmr_to_s",  64'(irq_to_s_o), 64'd0);
    irq_ready_i = 1'b1;
    tick();
    irq_ready_i = 1'b0; timer_irq_i = 1'b0;
    @(negedge clk);
    chk("tmr_settle", 64'(irq_valid_o), 64'd0);
    tick();

    // Delegated supervisor timer: blocked in M, taken in S
    priv_i = 2'd3; mstatus_sie_i = 1'b1;
    wr(12'h303, 64'h20);
    wr(12'h304, 64'h20);
    wr(12'h344, 64'h20);
    csr_raddr_i = 12'h104;
    @(negedge clk);
    chk("deleg_in_m", 64'(irq_valid_o), 64'd0);
    chk("deleg_sie",  csr_rdata_o, 64'h20);
    tick();
    priv_i = 2'd1;
    tick();
    @(negedge clk);
    chk("deleg_valid", 64'(irq_valid_o), 64'd1);
    chk("deleg_cause", irq_cause_o, 64'h8000_0000_0000_0005);
    chk("deleg_to_s",  64'(irq_to_s_o), 64'd1);
    tick();
    // Accept while clearing mip in the same cycle
    irq_ready_i = 1'b1; csr_we_i = 1'b1; csr_waddr_i = 12'h344; csr_wdata_i = 64'h0;
    tick();
    irq_ready_i = 1'b0; csr_we_i = 1'b0; csr_raddr_i = 12'h344;
    @(negedge clk);
    chk("deleg_settle", 64'(irq_valid_o), 64'd0);
    chk("deleg_kept",   irq_cause_o, 64'h8000_0000_0000_0005);
    chk("deleg_mip0",   csr_rdata_o, 64'h0);
    tick();

    // Priority 7 over 9 over 1, offer held stable until accepted
    priv_i = 2'd3; mstatus_mie_i = 1'b0;
    wr(12'h303, 64'h0);
    wr(12'h304, 64'h282);
    wr(12'h344, 64'h202);
    timer_irq_i = 1'b1; mstatus_mie_i = 1'b1;
    tick();
    @(negedge clk);
    chk("prio_cause", irq_cause_o, 64'h8000_0000_0000_0007);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("prio_hold", irq_cause_o, 64'h8000_0000_0000_0007);
    end
    tick();
    timer_irq_i = 1'b0;
    @(negedge clk);
    chk("prio_drop_valid", 64'(irq_valid_o), 64'd1);
    chk("prio_drop_cause", irq_cause_o, 64'h8000_0000_0000_0007);
    tick();
    irq_ready_i = 1'b1;
    tick();
    irq_ready_i = 1'b0;
    @(negedge clk);
    chk("prio_settle", 64'(irq_valid_o), 64'd0);
    tick();
    @(negedge clk);
    chk("prio_idle", 64'(irq_valid_o), 64'd0);
    tick();
    @(negedge clk);
    chk("prio_next_valid", 64'(irq_valid_o), 64'd1);
    chk("prio_next_cause", irq_cause_o, 64'h8000_0000_0000_0009);
    tick();
    irq_ready_i = 1'b1; mstatus_mie_i = 1'b0;
    csr_we_i = 1'b1; csr_waddr_i = 12'h344; csr_wdata_i = 64'h0;
    tick();
    irq_ready_i = 1'b0; csr_we_i = 1'b0; csr_raddr_i = 12'h344;
    @(negedge clk);
    chk("prio_acc_cause", irq_cause_o, 64'h8000_0000_0000_0009);
    chk("prio_acc_mip",   csr_rdata_o, 64'h0);

    // Synchroniser latency on line 9, and ignored internal lines
    tick();
    irq_ext_i = 16'h0200;
    @(negedge clk);
    chk("sync_c1", csr_rdata_o, 64'h0);
    tick();
    irq_ext_i = 16'h0000;
    @(negedge clk);
    chk("sync_c2", csr_rdata_o, 64'h0);
    tick();
    @(negedge clk);
    chk("sync_c3", csr_rdata_o, 64'h200);
    tick();
    @(negedge clk);
    chk("sync_c4", csr_rdata_o, 64'h0);
    tick();
    irq_ext_i = 16'h0888;
    repeat (3) tick();
    @(negedge clk);
    chk("sync_ignored", csr_rdata_o, 64'h0);
    tick();
    irq_ext_i = 16'h0000;

    // Asynchronous reset in the middle of an offer
    priv_i = 2'd0; msip_i = 1'b1;
    wr(12'h304, 64'h8);
    tick();
    @(negedge clk);
    chk("rst_pre_valid", 64'(irq_valid_o), 64'd1);
    chk("rst_pre_cause", irq_cause_o, 64'h8000_0000_0000_0003);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_valid", 64'(irq_valid_o), 64'd0);
    chk("rst_async_cause", irq_cause_o, 64'd0);
    tick();
    tick();
    rstn = 1'b1; msip_i = 1'b0;
    foreach (rd_addrs[k]) begin
      csr_raddr_i = rd_addrs[k];
      @(negedge clk);
      chk("rst_csr_zero", csr_rdata_o, 64'h0);
      tick();
    end

`ifdef TRAP_TIMER_EN
    // Internal timer: fire at mtime == mtimecmp, then wrap at the top
    priv_i = 2'd3; mstatus_mie_i = 1'b0;
    wr(12'h7C0, 64'h0);
    wr(12'h7C1, 64'd10);
    wr(12'h304, 64'h80);
    priv_i = 2'd0; csr_raddr_i = 12'h7C0;
    tm_found = 1'b0; tm_seen = '0;
    for (int i = 0; i < 20 && !tm_found; i++) begin
      @(negedge clk);
      if (irq_valid_o) begin
        tm_found = 1'b1;
        tm_seen  = csr_rdata_o;
      end
    end
    chk("tm_found", 64'(tm_found), 64'd1);
    chk("tm_mtime_at_valid", tm_seen, 64'd11);
    tick();
    irq_ready_i = 1'b1; csr_we_i = 1'b1; csr_waddr_i = 12'h304; csr_wdata_i = 64'h0;
    tick();
    irq_ready_i = 1'b0;
    wr(12'h7C0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("tm_max", csr_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    csr_raddr_i = 12'h344;
    @(negedge clk);
    chk("tm_wrap_mtip", csr_rdata_o, 64'h0);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
